// File: rtl/decoder_scan_seq_if.sv
// Select-bus interface for decoder_scan_seq: command inputs from the
// controlling FSM and the registered select outputs back to it.
interface decoder_scan_seq_if #(
    parameter int ADDR_W = 3
);
    localparam int NSEL = 1 << ADDR_W;

    logic              en;
    logic              load;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] scan_last;
    logic [NSEL-1:0]   sel;
    logic [ADDR_W-1:0] cur_addr;
    logic              wrap;
    logic              busy;

    modport master (
        output en, load, mode, addr_in, scan_last,
        input  sel, cur_addr, wrap, busy
    );

    modport slave (
        input  en, load, mode, addr_in, scan_last,
        output sel, cur_addr, wrap, busy
    );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered one-hot select sequencer: direct, auto-scan and one-shot pulse
// modes. Every output comes straight from a flop so the select lines never
// glitch.
module decoder_scan_seq #(
    parameter int ADDR_W    = 3,
    parameter int DWELL     = 4,
    parameter int PULSE_LEN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    decoder_scan_seq_if.slave  bus
);
    localparam int NSEL  = 1 << ADDR_W;
    // One counter serves both the scan dwell and the pulse length.
    localparam int CMAX  = (DWELL > PULSE_LEN) ? DWELL : PULSE_LEN;
    localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN, PULSE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NSEL-1:0]   sel_q, sel_d;
    logic              wrap_q, wrap_d;
    logic              busy_q, busy_d;

    // A pulse in flight cannot be interrupted by a new command, only by en.
    logic accept, dwell_done, pulse_done;
    assign accept     = bus.en && bus.load && (state_q != PULSE);
    assign dwell_done = (cnt_q == CNT_W'(DWELL - 1));
    assign pulse_done = (cnt_q == CNT_W'(PULSE_LEN - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: en low beats load, load beats internal sequencing.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = IDLE;
        end else if (accept) begin
            case (bus.mode)
                MODE_DIRECT: state_d = DIRECT;
                MODE_SCAN:   state_d = SCAN;
                MODE_PULSE:  state_d = PULSE;
                default:     state_d = IDLE;
            endcase
        end else if (state_q == PULSE && pulse_done) begin
            state_d = IDLE;
        end
    end

    // Next outputs: counter, address, wrap pulse and the one-hot select.
    always_comb begin
        cnt_d  = cnt_q;
        addr_d = addr_q;
        wrap_d = 1'b0;
        if (!bus.en) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = '0;
            // Clear leaves the last address visible on cur_addr.
            if (bus.mode != 2'b11) addr_d = bus.addr_in;
        end else if (state_q == SCAN) begin
            if (dwell_done) begin
                cnt_d = '0;
                // >= so a limit lowered under the current row wraps at once.
                if (addr_q >= bus.scan_last) begin
                    addr_d = '0;
                    wrap_d = 1'b1;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == PULSE) begin
            cnt_d = pulse_done ? '0 : cnt_q + 1'b1;
        end
        busy_d = (state_d == PULSE);
        sel_d  = (state_d != IDLE) ? (NSEL'(1) << addr_d) : '0;
    end

    // Output and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
            sel_q  <= '0;
            wrap_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            sel_q  <= sel_d;
            wrap_q <= wrap_d;
            busy_q <= busy_d;
        end
    end

    assign bus.sel      = sel_q;
    assign bus.cur_addr = addr_q;
    assign bus.wrap     = wrap_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: directed scenarios plus random traffic, all
// checked against a behavioural model of the select sequencer.
module tb_decoder_scan_seq;
    localparam int ADDR_W    = 3;
    localparam int DWELL     = 2;
    localparam int PULSE_LEN = 3;
    localparam int NSEL      = 1 << ADDR_W;

    localparam int K_IDLE = 0, K_DIRECT = 1, K_SCAN = 2, K_PULSE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    decoder_scan_seq_if #(.ADDR_W(ADDR_W)) bus ();

    decoder_scan_seq #(.ADDR_W(ADDR_W), .DWELL(DWELL), .PULSE_LEN(PULSE_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what is selected, for how long it has been selected,
    // and how much pulse time remains.
    int m_kind, m_row, m_age, m_left;
    bit m_wrap;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind = K_IDLE; m_row = 0; m_age = 0; m_left = 0; m_wrap = 0;
        end else begin
            m_wrap = 0;
            if (!bus.en) begin
                m_kind = K_IDLE;
            end else if (bus.load && m_kind != K_PULSE) begin
                case (bus.mode)
                    2'd0: begin m_kind = K_DIRECT; m_row = int'(bus.addr_in); end
                    2'd1: begin m_kind = K_SCAN; m_row = int'(bus.addr_in); m_age = 0; end
                    2'd2: begin m_kind = K_PULSE; m_row = int'(bus.addr_in); m_left = PULSE_LEN; end
                    default: m_kind = K_IDLE;
                endcase
            end else if (m_kind == K_SCAN) begin
                m_age++;
                if (m_age == DWELL) begin
                    m_age = 0;
                    if (m_row >= int'(bus.scan_last)) begin m_row = 0; m_wrap = 1; end
                    else m_row++;
                end
            end else if (m_kind == K_PULSE) begin
                m_left--;
                if (m_left == 0) m_kind = K_IDLE;
            end
        end
    end

    function automatic logic [NSEL+ADDR_W+1:0] exp_vec();
        logic [NSEL-1:0] s;
        s = (m_kind != K_IDLE) ? NSEL'(1) << m_row : '0;
        return {s, ADDR_W'(m_row), m_wrap, (m_kind == K_PULSE)};
    endfunction

    function automatic logic [NSEL+ADDR_W+1:0] got_vec();
        return {bus.sel, bus.cur_addr, bus.wrap, bus.busy};
    endfunction

    task automatic drive(input logic e, input logic l, input logic [1:0] m,
                         input logic [ADDR_W-1:0] a);
        bus.en = e; bus.load = l; bus.mode = m; bus.addr_in = a;
    endtask

    task automatic test_reset();
        drive(1, 1, 2'd1, 3'd2); bus.scan_last = 3'd7;
        @(negedge clk);
        drive(1, 0, 2'd0, 3'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (bus.sel !== 8'h00 || bus.busy !== 1'b0 || bus.wrap !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_async sel=%h busy=%b wrap=%b want 00/0/0", bus.sel, bus.busy, bus.wrap);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compared++;
            if (bus.sel !== 8'h00 || got_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL reset_idle cyc%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_direct();
        drive(1, 1, 2'd0, 3'd5);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.load = 0;
            compared++;
            if (bus.sel !== 8'h20 || bus.cur_addr !== 3'd5 || got_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL direct5 cyc%0d got=%h want sel=20 model=%h", i, got_vec(), exp_vec());
            end
        end
        drive(1, 1, 2'd0, 3'd0);
        @(negedge clk);
        bus.load = 0;
        compared++;
        if (bus.sel !== 8'h01 || got_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL direct0 got=%h want sel=01 model=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_scan();
        logic [7:0] es [7] = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
        logic       ew [7] = '{0, 0, 0, 0, 1, 0, 0};
        drive(1, 1, 2'd1, 3'd6); bus.scan_last = 3'd7;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.load = 0;
            compared++;
            if (bus.sel !== es[i] || bus.wrap !== ew[i] || got_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL scan cyc%0d sel=%h wrap=%b want %h/%b", i, bus.sel, bus.wrap, es[i], ew[i]);
            end
        end
    endtask

    task automatic test_scan_limit();
        int  n = 0;
        bit  seen_wrap = 0;
        drive(1, 1, 2'd1, 3'd3); bus.scan_last = 3'd7;
        @(negedge clk); bus.load = 0;
        while (bus.cur_addr !== 3'd5 && n < 20) begin @(negedge clk); n++; end
        compared++;
        if (bus.cur_addr !== 3'd5) begin
            mismatched++;
            $display("FAIL limit_reach cur_addr=%0d want 5", bus.cur_addr);
        end
        bus.scan_last = 3'd2;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (bus.wrap) seen_wrap = 1;
            compared++;
            if (got_vec() !== exp_vec() || (seen_wrap && bus.cur_addr > 3'd2)) begin
                mismatched++;
                $display("FAIL limit cyc%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        compared++;
        if (!seen_wrap) begin
            mismatched++;
            $display("FAIL limit_wrap wrap seen=0 want 1");
        end
    endtask

    task automatic test_oneshot();
        int busy_cyc = 0;
        drive(1, 1, 2'd2, 3'd3);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            // Retry load through the pulse and the cycle it ends, then stop.
            drive(1, (i < 4), 2'd2, 3'd1);
            if (i < 4 && bus.busy === 1'b1) busy_cyc++;
            compared++;
            if (got_vec() !== exp_vec() || (i < 3 && bus.sel !== 8'h08) || (i == 3 && bus.sel !== 8'h00)
                || (i == 4 && bus.sel !== 8'h02)) begin
                mismatched++;
                $display("FAIL oneshot cyc%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
        compared++;
        if (busy_cyc != PULSE_LEN) begin
            mismatched++;
            $display("FAIL oneshot_len busy cycles=%0d want %0d", busy_cyc, PULSE_LEN);
        end
    endtask

    task automatic test_en_override();
        drive(1, 1, 2'd1, 3'd0); bus.scan_last = 3'd7;
        repeat (3) begin @(negedge clk); bus.load = 0; end
        drive(0, 1, 2'd1, 3'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 0, 2'd1, 3'd4);
            compared++;
            if (bus.sel !== 8'h00 || bus.wrap !== 1'b0 || got_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL en_override cyc%0d got=%h want sel=00 model=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) bus.scan_last = 3'($urandom_range(0, 7));
            @(negedge clk);
            compared++;
            if (got_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL random cyc%0d got=%h want=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        drive(0, 0, 2'd0, 3'd0);
        bus.scan_last = 3'd7;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus.en = 1'b1;
        @(negedge clk);
        test_reset();
        test_direct();
        test_scan();
        test_scan_limit();
        test_oneshot();
        test_en_override();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
